i2s_tx_sequencer: RTL and testbench

I2S_TX_SEQUENCER -- requirements
Module: i2s_tx_sequencer

---
 rtl/i2s_tx_sequencer_if.sv | 12 +
 rtl/i2s_tx_sequencer.sv | 142 ++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_sequencer_if.sv
// Sample-pair input port of the I2S transmit sequencer.
// Handshake: a pair transfers on a ck edge where in_valid && in_ready; the source
// holds in_valid/in_left/in_right steady until then, and in_ready never waits on in_valid.
interface i2s_tx_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_tx_sequencer.sv
// Frame sequencer for an I2S transmitter: divides ck into sck, tracks bit position and
// word select, and moves one buffered stereo pair into left/right at every frame wrap.
module i2s_tx_sequencer #(
  parameter int CLOCKS = 64,
  parameter int DIV    = 2
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic                run,
  input  logic                clr_underrun,
  i2s_tx_sequencer_if.slave   in_if,
  output logic                sck,
  output logic                ws,
  output logic                en,
  output logic [5:0]          frame_posn,
  output logic [15:0]         left,
  output logic [15:0]         right,
  output logic                frame_start,
  output logic [7:0]          underrun,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int              DIV_W     = (2 * DIV > 2) ? $clog2(2 * DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(DIV);
  localparam logic [5:0]      POSN_LAST = 6'(CLOCKS - 1);
  localparam logic [5:0]      POSN_HALF = 6'(CLOCKS / 2);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [5:0]        posn_inc;
  logic              wrap;
  logic              accept;
  logic              full;
  logic [15:0]       buf_l;
  logic [15:0]       buf_r;

  always_comb begin
    div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    posn_inc = (frame_posn == POSN_LAST) ? 6'd0 : frame_posn + 6'd1;
    wrap     = en && (frame_posn == POSN_LAST);
    accept   = in_if.in_valid && !full;
  end

  assign in_if.in_ready = !full;
  assign dbg_state      = state;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      sck         <= 1'b0;
      ws          <= 1'b0;
      en          <= 1'b0;
      frame_posn  <= 6'd0;
      left        <= 16'd0;
      right       <= 16'd0;
      frame_start <= 1'b0;
      underrun    <= 8'd0;
      busy        <= 1'b0;
      full        <= 1'b0;
      buf_l       <= 16'd0;
      buf_r       <= 16'd0;
    end else begin
      // Accept needs an empty buffer and transfer needs a full one, so they never collide.
      if (accept) begin
        buf_l <= in_if.in_left;
        buf_r <= in_if.in_right;
        full  <= 1'b1;
      end

      case (state)
        IDLE: begin
          div_cnt     <= '0;
          sck         <= 1'b0;
          ws          <= 1'b0;
          en          <= 1'b0;
          frame_posn  <= 6'd0;
          left        <= 16'd0;
          right       <= 16'd0;
          frame_start <= 1'b0;
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (state == DRAIN && wrap && !run) begin
            state       <= IDLE;
            busy        <= 1'b0;
            div_cnt     <= '0;
            sck         <= 1'b0;
            ws          <= 1'b0;
            en          <= 1'b0;
            frame_posn  <= 6'd0;
            left        <= 16'd0;
            right       <= 16'd0;
            frame_start <= 1'b0;
          end else begin
            state   <= run ? RUN : DRAIN;
            busy    <= 1'b1;
            div_cnt <= div_nxt;
            sck     <= (div_nxt >= DIV_HALF);
            en      <= (div_nxt == DIV_LAST);
            // The en cycle after next can never be this one, so frame_posn is already final.
            frame_start <= (div_nxt == DIV_LAST) && (frame_posn == POSN_LAST);
            if (en) begin
              frame_posn <= posn_inc;
              ws         <= (posn_inc >= POSN_HALF);
            end
            if (wrap) begin
              if (full) begin
                left  <= buf_l;
                right <= buf_r;
                full  <= 1'b0;
              end else begin
                left  <= 16'd0;
                right <= 16'd0;
                if (underrun != 8'hFF) underrun <= underrun + 8'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (clr_underrun) underrun <= 8'd0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: a 64/2 instance for framing, buffering, drain and reset,
// and a 32/1 instance for fast timing and underrun saturation.
module tb_i2s_tx_sequencer;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst_n, rst1_n, run0, run1, clr0, clr1;
  logic sck0, ws0, en0, fs0, busy0, sck1, ws1, en1, fs1, busy1;
  logic [5:0]  posn0, posn1;
  logic [15:0] left0, right0, left1, right1;
  logic [7:0]  und0, und1;
  logic [1:0]  st0, st1;

  i2s_tx_sequencer_if if0();
  i2s_tx_sequencer_if if1();

  i2s_tx_sequencer #(.CLOCKS(64), .DIV(2)) dut0 (
    .ck(ck), .rst_n(rst_n), .run(run0), .clr_underrun(clr0), .in_if(if0),
    .sck(sck0), .ws(ws0), .en(en0), .frame_posn(posn0), .left(left0), .right(right0),
    .frame_start(fs0), .underrun(und0), .busy(busy0), .dbg_state(st0)
  );

  i2s_tx_sequencer #(.CLOCKS(32), .DIV(1)) dut1 (
    .ck(ck), .rst_n(rst1_n), .run(run1), .clr_underrun(clr1), .in_if(if1),
    .sck(sck1), .ws(ws1), .en(en1), .frame_posn(posn1), .left(left1), .right(right1),
    .frame_start(fs1), .underrun(und1), .busy(busy1), .dbg_state(st1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  bit mon_en = 1'b0;

  typedef struct {
    bit          offer;
    logic [15:0] l;
    logic [15:0] r;
    bit          clr;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [7:0]  exp_u;
  } vec_t;
  vec_t vec[11];
  logic [15:0] rl, rr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer0(input logic [15:0] l, input logic [15:0] r);
    int g;
    g = 0;
    @(negedge ck);
    if0.in_valid = 1'b1;
    if0.in_left  = l;
    if0.in_right = r;
    while (!if0.in_ready && g < 2000) begin
      @(negedge ck);
      g++;
    end
    if (!if0.in_ready) begin
      check("offer_timeout", {31'd0, if0.in_ready}, 32'd1);
      if0.in_valid = 1'b0;
    end else begin
      @(posedge ck);
      exp_q.push_back({l, r});
      #1 if0.in_valid = 1'b0;
    end
  endtask

  task automatic wait_fs0();
    int g;
    g = 0;
    do begin
      @(negedge ck);
      g++;
    end while (!fs0 && g < 600);
    if (!fs0) check("wait_frame_start_timeout", {31'd0, fs0}, 32'd1);
  endtask

  task automatic wait_posn0(input logic [5:0] target);
    int g;
    g = 0;
    do begin
      @(negedge ck);
      g++;
    end while (posn0 != target && g < 600);
    if (posn0 != target) check("wait_posn_timeout", {26'd0, posn0}, {26'd0, target});
  endtask

  // Timing and pair scoreboard for dut0, sampled on the falling edge.
  int en_gap = -1;
  int fs_gap = -1;
  bit pend_en = 1'b0;
  bit pend_fs = 1'b0;
  logic [5:0] en_posn;
  logic [31:0] mon_exp;
  int nxt;

  always @(negedge ck) begin
    if (!mon_en) begin
      en_gap = -1; fs_gap = -1; pend_en = 1'b0; pend_fs = 1'b0;
    end else begin
      if (pend_en) begin
        nxt = (int'(en_posn) + 1) % 64;
        check("posn_step", {26'd0, posn0}, nxt);
        check("ws_for_posn", {31'd0, ws0}, (nxt >= 32) ? 32'd1 : 32'd0);
        check("sck_low_after_en", {31'd0, sck0}, 32'd0);
        pend_en = 1'b0;
      end
      if (pend_fs) begin
        if (!busy0 || exp_q.size() == 0) mon_exp = 32'd0;
        else mon_exp = exp_q.pop_front();
        check("pair_after_wrap", {left0, right0}, mon_exp);
        pend_fs = 1'b0;
      end
      check("frame_start_at_wrap", {31'd0, fs0}, (en0 && posn0 == 6'd63) ? 32'd1 : 32'd0);
      if (en_gap >= 0) en_gap++;
      if (fs_gap >= 0) fs_gap++;
      if (en0) begin
        check("sck_high_at_en", {31'd0, sck0}, 32'd1);
        if (en_gap >= 0) check("en_period", en_gap, 32'd4);
        en_gap = 0; pend_en = 1'b1; en_posn = posn0;
      end
      if (fs0) begin
        if (fs_gap >= 0) check("frame_period", fs_gap, 32'd256);
        fs_gap = 0; pend_fs = 1'b1;
      end
      if (!busy0) begin
        en_gap = -1; fs_gap = -1;
      end
    end
  end

  initial begin
    #1_500_000;
    check("watchdog", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int cnt, g, gap, ens, fs_cnt, ex;
    bit pend, fs_pend;
    logic [5:0] p;

    rst_n = 1'b0; rst1_n = 1'b0; run0 = 1'b0; run1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_left = 16'd0; if0.in_right = 16'd0;
    if1.in_valid = 1'b0; if1.in_left = 16'd0; if1.in_right = 16'd0;

    rl = 16'($urandom_range(0, 65535));
    rr = 16'($urandom_range(0, 65535));
    vec[0]  = '{1'b1, 16'h1111, 16'h2222, 1'b0, 16'h1111, 16'h2222, 8'd0};
    vec[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'd1};
    vec[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'd2};
    vec[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'd3};
    vec[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 8'd0};
    vec[5]  = '{1'b1, 16'hABCD, 16'h1234, 1'b0, 16'hABCD, 16'h1234, 8'd0};
    vec[6]  = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 8'd0};
    vec[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 8'd1};
    vec[8]  = '{1'b1, 16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h8000, 8'd0};
    vec[9]  = '{1'b1, rl, rr, 1'b0, rl, rr, 8'd0};
    vec[10] = '{1'b1, rr, rl, 1'b0, rr, rl, 8'd0};

    // Reset values, observed before any clock edge.
    #3;
    check("rst_sck", {31'd0, sck0}, 32'd0);
    check("rst_ws", {31'd0, ws0}, 32'd0);
    check("rst_en", {31'd0, en0}, 32'd0);
    check("rst_posn", {26'd0, posn0}, 32'd0);
    check("rst_pair", {left0, right0}, 32'd0);
    check("rst_frame_start", {31'd0, fs0}, 32'd0);
    check("rst_underrun", {24'd0, und0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
    check("rst_state", {30'd0, st0}, 32'd0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge ck);
    check("idle_busy", {31'd0, busy0}, 32'd0);
    mon_en = 1'b1;

    // First pair while empty, then the first wrap transfers it.
    run0 = 1'b1;
    offer0(16'h8001, 16'h7FFE);
    @(negedge ck);
    check("ready_drops_after_accept", {31'd0, if0.in_ready}, 32'd0);
    check("busy_in_run", {31'd0, busy0}, 32'd1);
    wait_fs0();
    check("first_wrap_posn", {26'd0, posn0}, 32'd63);
    check("first_wrap_en", {31'd0, en0}, 32'd1);
    @(negedge ck);
    check("first_pair", {left0, right0}, 32'h8001_7FFE);
    check("first_pair_posn", {26'd0, posn0}, 32'd0);
    check("ready_after_transfer", {31'd0, if0.in_ready}, 32'd1);
    check("first_pair_underrun", {24'd0, und0}, 32'd0);

    // One table entry per frame: optional pair, optional clear at the wrap.
    for (int i = 0; i < 11; i++) begin
      if (vec[i].offer) offer0(vec[i].l, vec[i].r);
      wait_fs0();
      clr0 = vec[i].clr;
      @(negedge ck);
      clr0 = 1'b0;
      check($sformatf("vec%0d_left", i), {16'd0, left0}, {16'd0, vec[i].exp_l});
      check($sformatf("vec%0d_right", i), {16'd0, right0}, {16'd0, vec[i].exp_r});
      check($sformatf("vec%0d_underrun", i), {24'd0, und0}, {24'd0, vec[i].exp_u});
    end

    // Second pair waits on a full buffer and lands the cycle after the transfer.
    offer0(16'h0A0A, 16'h0B0B);
    offer0(16'h0C0C, 16'h0D0D);
    @(negedge ck);
    check("b2b_ready_low", {31'd0, if0.in_ready}, 32'd0);
    check("b2b_posn", {26'd0, posn0}, 32'd0);
    check("b2b_left", {16'd0, left0}, 32'h0A0A);
    wait_fs0();
    @(negedge ck);

    // Drain from posn 10 finishes the frame, then idles.
    wait_posn0(6'd10);
    run0 = 1'b0;
    cnt = 0; g = 0;
    do begin
      @(negedge ck);
      g++;
      if (busy0 && en0) cnt++;
    end while (busy0 && g < 400);
    check("drain_en_count", cnt, 32'd54);
    check("drain_idle_state", {30'd0, st0}, 32'd0);
    check("drain_idle_sck", {31'd0, sck0}, 32'd0);
    check("drain_idle_posn", {26'd0, posn0}, 32'd0);
    check("drain_idle_ws", {31'd0, ws0}, 32'd0);
    check("drain_idle_pair", {left0, right0}, 32'd0);
    @(negedge ck);
    check("idle_en", {31'd0, en0}, 32'd0);

    // Re-assert run while draining: the stream carries on without a gap.
    run0 = 1'b1;
    wait_posn0(6'd10);
    run0 = 1'b0;
    wait_posn0(6'd30);
    check("in_drain_state", {30'd0, st0}, 32'd2);
    check("in_drain_busy", {31'd0, busy0}, 32'd1);
    run0 = 1'b1;
    wait_fs0();
    @(negedge ck);
    check("resume_state", {30'd0, st0}, 32'd1);
    check("resume_posn", {26'd0, posn0}, 32'd0);
    check("resume_busy", {31'd0, busy0}, 32'd1);

    // Asynchronous reset mid-frame with a full buffer.
    offer0(16'h5555, 16'hAAAA);
    wait_posn0(6'd40);
    check("pre_reset_full", {31'd0, if0.in_ready}, 32'd0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_sck", {31'd0, sck0}, 32'd0);
    check("arst_ws", {31'd0, ws0}, 32'd0);
    check("arst_en", {31'd0, en0}, 32'd0);
    check("arst_posn", {26'd0, posn0}, 32'd0);
    check("arst_pair", {left0, right0}, 32'd0);
    check("arst_frame_start", {31'd0, fs0}, 32'd0);
    check("arst_underrun", {24'd0, und0}, 32'd0);
    check("arst_busy", {31'd0, busy0}, 32'd0);
    check("arst_in_ready", {31'd0, if0.in_ready}, 32'd1);
    exp_q.delete();
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    g = 0;
    do begin
      @(negedge ck);
      g++;
    end while (!en0 && g < 20);
    check("post_reset_first_en", {31'd0, en0}, 32'd1);
    check("post_reset_fresh_posn", {26'd0, posn0}, 32'd0);
    run0 = 1'b0;

    // CLOCKS=32, DIV=1: fast timing, then underrun saturation with no data.
    @(negedge ck);
    run1 = 1'b1;
    gap = -1; ens = 0; fs_cnt = 0; g = 0; pend = 1'b0; fs_pend = 1'b0; p = 6'd0;
    while (!(fs_cnt >= 300 && !fs_pend) && g < 21000) begin
      @(negedge ck);
      g++;
      if (fs_pend) begin
        fs_pend = 1'b0;
        if (fs_cnt == 1 || fs_cnt == 2 || fs_cnt == 100 || fs_cnt == 254 ||
            fs_cnt == 255 || fs_cnt == 256 || fs_cnt == 300) begin
          ex = (fs_cnt > 255) ? 255 : fs_cnt;
          check($sformatf("d1_underrun_after_%0d", fs_cnt), {24'd0, und1}, ex);
          check("d1_pair_zero", {left1, right1}, 32'd0);
        end
      end
      if (fs1) begin
        fs_cnt++;
        fs_pend = 1'b1;
      end
      if (g <= 100) begin
        if (pend) begin
          ex = (int'(p) + 1) % 32;
          check("d1_posn_step", {26'd0, posn1}, ex);
          check("d1_ws", {31'd0, ws1}, (ex >= 16) ? 32'd1 : 32'd0);
          pend = 1'b0;
        end
        if (gap >= 0) gap++;
        if (en1) begin
          if (gap >= 0) check("d1_en_period", gap, 32'd2);
          check("d1_frame_start", {31'd0, fs1}, (posn1 == 6'd31) ? 32'd1 : 32'd0);
          gap = 0; pend = 1'b1; p = posn1; ens++;
        end
      end
    end
    check("d1_en_count", ens, 32'd50);
    check("d1_frames_seen", fs_cnt, 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
